// File: rtl/sync_updown_counter.sv
// sync_updown_counter
// Parametrised synchronous binary counter with configurable width and modulus,
// up/down direction, count enable, synchronous clear, clamped parallel load,
// wrap or saturate behaviour at the range ends, terminal-count output for
// cascading, a one-cycle wrap/saturation pulse and a sticky event flag.

module sync_updown_counter #(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter int              SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    // Reject unusable parameter sets at elaboration time rather than
    // silently building a counter with a broken range.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("sync_updown_counter: WIDTH must be in 1..32");
        end
        if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
            $error("sync_updown_counter: MODULUS must be in 2..2**WIDTH");
        end
        if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
            $error("sync_updown_counter: SATURATE must be 0 or 1");
        end
    endgenerate

    // Highest value the counter may ever hold. The range end is found by an
    // explicit compare against this, so non-power-of-two moduli wrap correctly
    // instead of relying on the adder rolling over at 2**WIDTH.
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);
    localparam bit               SAT_MODE = (SATURATE != 0);

    logic at_top;
    logic at_bottom;
    logic at_end;
    logic terminal;

    assign at_top    = (Q == MAX_VAL);
    assign at_bottom = (Q == '0);
    assign at_end    = up_dn ? at_top : at_bottom;

    // A terminal event is an enabled step that would leave the range in the
    // current direction; load and clear take priority and suppress it.
    assign terminal  = en & ~load & ~clr & at_end;

    // Terminal count looks one edge ahead so a following counter stage can
    // use it as its enable; it is masked while reset is being applied.
    assign tc        = terminal & reset_n;

    // Counter state, wrap pulse and sticky flag, updated in priority order:
    // reset, clear, load, count, hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            Q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (clr) begin
            Q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (load) begin
            Q    <= (load_val > MAX_VAL) ? MAX_VAL : load_val;
            wrap <= 1'b0;
        end else if (en) begin
            if (up_dn) begin
                if (at_top) begin
                    Q <= SAT_MODE ? MAX_VAL : '0;
                end else begin
                    Q <= Q + 1'b1;
                end
            end else begin
                if (at_bottom) begin
                    Q <= SAT_MODE ? '0 : MAX_VAL;
                end else begin
                    Q <= Q - 1'b1;
                end
            end
            wrap <= at_end;
            if (at_end) begin
                ovf <= 1'b1;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_updown_counter.sv
// tb_sync_updown_counter
// Drives three counter configurations from one shared stimulus stream:
// modulo-10 wrap, modulo-16 wrap and modulo-16 saturate. A reference model
// computes the expected outputs from the counting rules with plain integer
// arithmetic; expectations are queued and popped by independent monitors.

module tb_sync_updown_counter;

    localparam int NUM_DUT = 3;
    localparam int MODS [NUM_DUT] = '{10, 16, 16};
    localparam bit SATS [NUM_DUT] = '{1'b0, 1'b0, 1'b1};

    logic       clk;
    logic       reset_n;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up_dn;

    logic [3:0] q_dut    [NUM_DUT];
    logic       tc_dut   [NUM_DUT];
    logic       wrap_dut [NUM_DUT];
    logic       ovf_dut  [NUM_DUT];

    typedef struct packed {
        logic [NUM_DUT-1:0][3:0] q;
        logic [NUM_DUT-1:0]      wrap;
        logic [NUM_DUT-1:0]      ovf;
    } exp_state_t;

    exp_state_t         state_q [$];
    logic [NUM_DUT-1:0] tc_q    [$];

    int m_q    [NUM_DUT];
    bit m_wrap [NUM_DUT];
    bit m_ovf  [NUM_DUT];

    int checks = 0;
    int errors = 0;

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_mod10 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .Q(q_dut[0]), .tc(tc_dut[0]), .wrap(wrap_dut[0]),
        .ovf(ovf_dut[0])
    );

    sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_mod16 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .Q(q_dut[1]), .tc(tc_dut[1]), .wrap(wrap_dut[1]),
        .ovf(ovf_dut[1])
    );

    sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1)) dut_sat16 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .Q(q_dut[2]), .tc(tc_dut[2]), .wrap(wrap_dut[2]),
        .ovf(ovf_dut[2])
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expectation and tally the result.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, step the reference model
    // and queue the expected terminal count and post-edge state.
    task automatic applyStimulus(input logic rn, input logic c, input logic l,
                                 input logic [3:0] lv, input logic e, input logic ud);
        exp_state_t         item;
        logic [NUM_DUT-1:0] tc_exp;
        @(negedge clk);
        reset_n  = rn;
        clr      = c;
        load     = l;
        load_val = lv;
        en       = e;
        up_dn    = ud;
        for (int k = 0; k < NUM_DUT; k++) begin
            int top;
            int nxt;
            bit at_end;
            top       = MODS[k] - 1;
            at_end    = ud ? (m_q[k] == top) : (m_q[k] == 0);
            tc_exp[k] = rn && !c && !l && e && at_end;
            if (!rn || c) begin
                m_q[k]    = 0;
                m_wrap[k] = 1'b0;
                m_ovf[k]  = 1'b0;
            end else if (l) begin
                m_q[k]    = (int'(lv) > top) ? top : int'(lv);
                m_wrap[k] = 1'b0;
            end else if (e) begin
                nxt = ud ? m_q[k] + 1 : m_q[k] - 1;
                if (nxt > top || nxt < 0) begin
                    m_wrap[k] = 1'b1;
                    m_ovf[k]  = 1'b1;
                    if (SATS[k]) nxt = m_q[k];
                    else         nxt = (nxt < 0) ? top : 0;
                end else begin
                    m_wrap[k] = 1'b0;
                end
                m_q[k] = nxt;
            end else begin
                m_wrap[k] = 1'b0;
            end
            item.q[k]    = 4'(m_q[k]);
            item.wrap[k] = m_wrap[k];
            item.ovf[k]  = m_ovf[k];
        end
        tc_q.push_back(tc_exp);
        state_q.push_back(item);
    endtask

    // Terminal-count monitor: tc is combinational, so it is checked shortly
    // after the inputs settle and well before the next rising edge.
    always begin : tc_monitor
        logic [NUM_DUT-1:0] tc_exp;
        @(negedge clk);
        #2;
        if (tc_q.size() > 0) begin
            tc_exp = tc_q.pop_front();
            for (int k = 0; k < NUM_DUT; k++) begin
                checkOutput($sformatf("tc[%0d]", k), int'(tc_dut[k]), int'(tc_exp[k]));
            end
        end
    end

    // Registered-output monitor: Q, wrap and ovf are checked just after the
    // rising edge that was supposed to produce them.
    always begin : state_monitor
        exp_state_t item;
        @(posedge clk);
        #1;
        if (state_q.size() > 0) begin
            item = state_q.pop_front();
            for (int k = 0; k < NUM_DUT; k++) begin
                checkOutput($sformatf("Q[%0d]", k),    int'(q_dut[k]),    int'(item.q[k]));
                checkOutput($sformatf("wrap[%0d]", k), int'(wrap_dut[k]), int'(item.wrap[k]));
                checkOutput($sformatf("ovf[%0d]", k),  int'(ovf_dut[k]),  int'(item.ovf[k]));
            end
        end
    end

    // Safety net so the run always ends even if the stimulus stalls.
    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized stretch, then drain and report.
    initial begin : stimulus
        bit dir;
        reset_n  = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        en       = 1'b0;
        up_dn    = 1'b1;
        for (int k = 0; k < NUM_DUT; k++) begin
            m_q[k]    = 0;
            m_wrap[k] = 1'b0;
            m_ovf[k]  = 1'b0;
        end

        $display("[TB] reset");
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

        $display("[TB] continuous up-count");
        repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

        $display("[TB] clear then continuous down-count");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);

        $display("[TB] out-of-range load is clamped");
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd12, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd5,  1'b0, 1'b1);

        $display("[TB] saturation at the top, then step down");
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd14, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        $display("[TB] control priority");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);

        $display("[TB] reset pulse mid-count");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

        $display("[TB] randomized operation");
        dir = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            applyStimulus(($urandom_range(0, 59) != 0),
                          ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 14) == 0),
                          4'($urandom_range(0, 15)),
                          ($urandom_range(0, 4) != 0),
                          dir);
        end

        repeat (3) @(negedge clk);
        checkOutput("tc_queue_drained",    tc_q.size(),    0);
        checkOutput("state_queue_drained", state_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
